// File: rtl/io_port_unit.sv
// io_port_unit -- stack-machine I/O port.
//   Output side: DEPTH-entry circular FIFO draining to an external device
//   through a valid/ready handshake. Writes into a full FIFO are dropped.
//   Input side: three-state capture FSM (IN_IDLE/IN_EMPTY/IN_FULL) holding
//   one device word until the control unit consumes it.
// Optional feature: define IO_PORT_OVF_COUNT_EN to add the ovf_count port,
//   a saturating 8-bit count of dropped output writes.
module io_port_unit #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              CLK,
   input  logic              reset_n,
   // control-unit side, output path
   input  logic              out_write,
   input  logic [DATA_W-1:0] out_data,
   output logic              out_full,
   // device side, output path
   output logic [DATA_W-1:0] dev_out_data,
   output logic              dev_out_valid,
   input  logic              dev_out_ready,
   // control-unit side, input path
   input  logic              in_read,
   output logic [DATA_W-1:0] in_data,
   output logic              in_valid,
   // device side, input path
   input  logic [DATA_W-1:0] dev_in_data,
   input  logic              dev_in_valid,
   output logic              dev_in_ready
`ifdef IO_PORT_OVF_COUNT_EN
   ,
   output logic [7:0]        ovf_count
`endif
);

   // ------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = AW + 1;

   localparam logic [PW-1:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
   localparam logic [PW-1:0] DEPTH_OCC = PW'(DEPTH);

   // Storage is deliberately left unreset: the head word is masked by the
   // valid flag, so stale contents never reach the device.
   logic [DATA_W-1:0] mem_r [DEPTH];

   logic [PW-1:0] wptr_r;
   logic [PW-1:0] rptr_r;
   logic          valid_r;
   logic          full_r;

   logic [PW-1:0] wptr_nxt_s;
   logic [PW-1:0] rptr_nxt_s;
   logic [PW-1:0] occ_nxt_s;
   logic          wr_en_s;
   logic          rd_en_s;
   logic          drop_s;

   // Decode this cycle's accepted write, device pop and dropped write.
   always_comb begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
      drop_s  = 1'b0;
      if (out_write && !full_r) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end
      if (valid_r && dev_out_ready) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
      if (out_write && full_r) begin
         drop_s = 1'b1;
      end else begin
         drop_s = 1'b0;
      end
   end

   // Next pointer values and the resulting occupancy (modulo 2^PW).
   always_comb begin
      wptr_nxt_s = wptr_r;
      rptr_nxt_s = rptr_r;
      if (wr_en_s) begin
         wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
         wptr_nxt_s = wptr_r;
      end
      if (rd_en_s) begin
         rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
         rptr_nxt_s = rptr_r;
      end
      occ_nxt_s = wptr_nxt_s - rptr_nxt_s;
   end

   // Pointer registers plus registered empty/full flags derived from the
   // next-state occupancy, so flags change on the same edge as pointers.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         wptr_r  <= PTR_ZERO;
         rptr_r  <= PTR_ZERO;
         valid_r <= 1'b0;
         full_r  <= 1'b0;
      end else begin
         wptr_r  <= wptr_nxt_s;
         rptr_r  <= rptr_nxt_s;
         valid_r <= (occ_nxt_s != PTR_ZERO);
         full_r  <= (occ_nxt_s == DEPTH_OCC);
      end
   end

   // Storage write for accepted output words.
   always_ff @(posedge CLK) begin
      if (wr_en_s) begin
         mem_r[wptr_r[AW-1:0]] <= out_data;
      end
   end

   // Head word is driven only from registers and is forced to zero while
   // the FIFO is empty (including throughout reset).
   always_comb begin
      dev_out_data = {DATA_W{1'b0}};
      if (valid_r) begin
         dev_out_data = mem_r[rptr_r[AW-1:0]];
      end else begin
         dev_out_data = {DATA_W{1'b0}};
      end
   end

   assign dev_out_valid = valid_r;
   assign out_full      = full_r;

`ifdef IO_PORT_OVF_COUNT_EN
   logic [7:0] ovf_cnt_r;

   // Saturating count of writes dropped because the FIFO was full.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         ovf_cnt_r <= 8'd0;
      end else if (drop_s && (ovf_cnt_r != 8'hFF)) begin
         ovf_cnt_r <= ovf_cnt_r + 8'd1;
      end else begin
         ovf_cnt_r <= ovf_cnt_r;
      end
   end

   assign ovf_count = ovf_cnt_r;
`else
   logic unused_drop_s;
   assign unused_drop_s = drop_s;
`endif

   // ------------------------------------------------------------------
   // Input capture FSM
   // ------------------------------------------------------------------
   localparam logic [1:0] IN_IDLE  = 2'd0;
   localparam logic [1:0] IN_EMPTY = 2'd1;
   localparam logic [1:0] IN_FULL  = 2'd2;

   logic [1:0]        in_state_r;
   logic [1:0]        in_state_nxt_s;
   logic [DATA_W-1:0] in_reg_r;
   logic              capture_s;

   // Next-state logic. A consume in IN_FULL always wins over a concurrent
   // device offer; that offer is taken at the following edge at the earliest.
   always_comb begin
      in_state_nxt_s = in_state_r;
      capture_s      = 1'b0;
      case (in_state_r)
         IN_IDLE: begin
            in_state_nxt_s = IN_EMPTY;
         end
         IN_EMPTY: begin
            if (dev_in_valid) begin
               in_state_nxt_s = IN_FULL;
               capture_s      = 1'b1;
            end else begin
               in_state_nxt_s = IN_EMPTY;
            end
         end
         IN_FULL: begin
            if (in_read) begin
               in_state_nxt_s = IN_EMPTY;
            end else begin
               in_state_nxt_s = IN_FULL;
            end
         end
         default: begin
            in_state_nxt_s = IN_IDLE;
         end
      endcase
   end

   // State register and captured input word.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         in_state_r <= IN_IDLE;
         in_reg_r   <= {DATA_W{1'b0}};
      end else begin
         in_state_r <= in_state_nxt_s;
         if (capture_s) begin
            in_reg_r <= dev_in_data;
         end else begin
            in_reg_r <= in_reg_r;
         end
      end
   end

   // Handshake outputs are pure decodes of the state register.
   always_comb begin
      dev_in_ready = 1'b0;
      in_valid     = 1'b0;
      in_data      = {DATA_W{1'b0}};
      if (in_state_r == IN_FULL) begin
         in_valid = 1'b1;
         in_data  = in_reg_r;
      end else begin
         in_valid = 1'b0;
         in_data  = {DATA_W{1'b0}};
      end
      if (in_state_r == IN_EMPTY) begin
         dev_in_ready = 1'b1;
      end else begin
         dev_in_ready = 1'b0;
      end
   end

endmodule

// File: tb/tb_io_port_unit.sv
// Directed self-checking bench for io_port_unit (DATA_W=16, DEPTH=4).
module tb_io_port_unit;

   localparam int DW = 16;

   logic          CLK;
   logic          reset_n;
   logic          out_write;
   logic [DW-1:0] out_data;
   logic          out_full;
   logic [DW-1:0] dev_out_data;
   logic          dev_out_valid;
   logic          dev_out_ready;
   logic          in_read;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic [DW-1:0] dev_in_data;
   logic          dev_in_valid;
   logic          dev_in_ready;
`ifdef IO_PORT_OVF_COUNT_EN
   logic [7:0]    ovf_count;
`endif

   int total_cnt = 0;
   int pass_cnt  = 0;

   io_port_unit #(.DATA_W(DW), .DEPTH(4)) dut (
      .CLK           (CLK),
      .reset_n       (reset_n),
      .out_write     (out_write),
      .out_data      (out_data),
      .out_full      (out_full),
      .dev_out_data  (dev_out_data),
      .dev_out_valid (dev_out_valid),
      .dev_out_ready (dev_out_ready),
      .in_read       (in_read),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .dev_in_data   (dev_in_data),
      .dev_in_valid  (dev_in_valid),
      .dev_in_ready  (dev_in_ready)
`ifdef IO_PORT_OVF_COUNT_EN
      ,
      .ovf_count     (ovf_count)
`endif
   );

   // 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Absolute time limit so the run can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_full"},   {31'd0, out_full},      32'd0);
      check({tag, "_ovalid"}, {31'd0, dev_out_valid}, 32'd0);
      check({tag, "_odata"},  {16'd0, dev_out_data},  32'd0);
      check({tag, "_ivalid"}, {31'd0, in_valid},      32'd0);
      check({tag, "_idata"},  {16'd0, in_data},       32'd0);
      check({tag, "_iready"}, {31'd0, dev_in_ready},  32'd0);
`ifdef IO_PORT_OVF_COUNT_EN
      check({tag, "_ovf"},    {24'd0, ovf_count},     32'd0);
`endif
   endtask

   logic [DW-1:0] fill_vals [4];

   initial begin
      fill_vals[0] = 16'h1111;
      fill_vals[1] = 16'h2222;
      fill_vals[2] = 16'h3333;
      fill_vals[3] = 16'h4444;

      reset_n       = 1'b0;
      out_write     = 1'b0;
      out_data      = 16'h0000;
      dev_out_ready = 1'b0;
      in_read       = 1'b0;
      dev_in_data   = 16'h0000;
      dev_in_valid  = 1'b0;

      #2;
      check_reset_outputs("rst");
      tick();
      tick();
      reset_n = 1'b1;
      // still in IN_IDLE until the first edge after release
      check("idle_iready", {31'd0, dev_in_ready}, 32'd0);
      tick();
      check("empty_iready", {31'd0, dev_in_ready}, 32'd1);
      check("empty_ivalid", {31'd0, in_valid},     32'd0);

      // Fill with device stalled.
      dev_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         out_write = 1'b1;
         out_data  = fill_vals[i];
         tick();
         check("fill_valid", {31'd0, dev_out_valid}, 32'd1);
         check("fill_head",  {16'd0, dev_out_data},  32'h1111);
         check("fill_full",  {31'd0, out_full},      (i == 3) ? 32'd1 : 32'd0);
      end
      out_write = 1'b0;
      tick();
      check("stall_hold", {16'd0, dev_out_data}, 32'h1111);

      // Write into full FIFO while device pops: write dropped.
      out_write     = 1'b1;
      out_data      = 16'h5555;
      dev_out_ready = 1'b1;
      tick();
      out_write     = 1'b0;
      dev_out_ready = 1'b0;
      check("drop_full", {31'd0, out_full},     32'd0);
      check("drop_head", {16'd0, dev_out_data}, 32'h2222);
`ifdef IO_PORT_OVF_COUNT_EN
      check("drop_ovf",  {24'd0, ovf_count},    32'd1);
`endif
      // Drain: exactly three words remain, 0x5555 never appears.
      dev_out_ready = 1'b1;
      tick();
      check("drain_3333", {16'd0, dev_out_data}, 32'h3333);
      tick();
      check("drain_4444", {16'd0, dev_out_data}, 32'h4444);
      tick();
      check("drain_empty", {31'd0, dev_out_valid}, 32'd0);
      check("drain_zero",  {16'd0, dev_out_data},  32'h0000);

      // Streaming with device always ready; pointers wrap.
      for (int i = 1; i <= 10; i++) begin
         out_write = 1'b1;
         out_data  = DW'(i);
         tick();
         check("stream_valid", {31'd0, dev_out_valid}, 32'd1);
         check("stream_data",  {16'd0, dev_out_data},  32'(i));
         check("stream_full",  {31'd0, out_full},      32'd0);
      end
      out_write = 1'b0;
      tick();
      check("stream_end", {31'd0, dev_out_valid}, 32'd0);
      dev_out_ready = 1'b0;

      // Input path: in_read while empty is ignored.
      in_read = 1'b1;
      tick();
      in_read = 1'b0;
      check("rd_empty_iready", {31'd0, dev_in_ready}, 32'd1);
      check("rd_empty_ivalid", {31'd0, in_valid},     32'd0);

      // Capture 0xBEEF.
      dev_in_valid = 1'b1;
      dev_in_data  = 16'hBEEF;
      tick();
      check("cap_ivalid", {31'd0, in_valid},     32'd1);
      check("cap_idata",  {16'd0, in_data},      32'hBEEF);
      check("cap_iready", {31'd0, dev_in_ready}, 32'd0);
      // Device offer ignored while full.
      dev_in_data = 16'h1234;
      tick();
      dev_in_valid = 1'b0;
      check("full_ignore", {16'd0, in_data}, 32'hBEEF);
      in_read = 1'b1;
      tick();
      in_read = 1'b0;
      check("consume_ivalid", {31'd0, in_valid},     32'd0);
      check("consume_idata",  {16'd0, in_data},      32'h0000);
      check("consume_iready", {31'd0, dev_in_ready}, 32'd1);

      // Consume and offer in the same full cycle.
      dev_in_valid = 1'b1;
      dev_in_data  = 16'hA5A5;
      tick();
      check("pre_cafe", {16'd0, in_data}, 32'hA5A5);
      in_read     = 1'b1;
      dev_in_data = 16'hCAFE;
      tick();
      in_read = 1'b0;
      check("cafe_skip_ivalid", {31'd0, in_valid},     32'd0);
      check("cafe_skip_iready", {31'd0, dev_in_ready}, 32'd1);
      tick();
      dev_in_valid = 1'b0;
      check("cafe_ivalid", {31'd0, in_valid}, 32'd1);
      check("cafe_idata",  {16'd0, in_data},  32'hCAFE);

      // Queue two words while IN_FULL, then reset mid-activity.
      out_write = 1'b1;
      out_data  = 16'h7777;
      tick();
      out_data  = 16'h8888;
      tick();
      out_write = 1'b0;
      check("q2_head", {16'd0, dev_out_data}, 32'h7777);
      dev_out_ready = 1'b1;
      dev_in_valid  = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      tick();
      reset_n = 1'b1;
      dev_out_ready = 1'b0;
      dev_in_valid  = 1'b0;
      check("post_rst_idle", {31'd0, dev_in_ready}, 32'd0);
      tick();
      check("post_rst_empty",  {31'd0, dev_in_ready},  32'd1);
      check("post_rst_ivalid", {31'd0, in_valid},      32'd0);
      check("post_rst_ovalid", {31'd0, dev_out_valid}, 32'd0);

      // FIFO is clean after reset: next write is the head.
      out_write = 1'b1;
      out_data  = 16'h9999;
      tick();
      out_write = 1'b0;
      check("post_rst_head", {16'd0, dev_out_data}, 32'h9999);
      check("post_rst_full", {31'd0, out_full},     32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
